prco_fetch: RTL

//  Instruction fetch stage, directly upstream of the PRCO decoder. Holds the PC and reads
//  one 16-bit instruction per request over a req/ack memory handshake.

---
 rtl/prco_fetch_pkg.sv | 14 +
 rtl/prco_fetch_pc.sv | 37 +++
 rtl/prco_fetch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/prco_fetch_pkg.sv
// Shared types and defaults for the PRCO instruction fetch stage.
package prco_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [15:0] PRCO_RESET_PC      = 16'h0000;
  localparam int          PRCO_FETCH_TIMEOUT = 15;
  localparam int          TIMER_W            = 8;

endpackage

// File: rtl/prco_fetch_pc.sv
// Program counter for the fetch stage: a load of a redirect target beats the increment.
module prco_fetch_pc
  import prco_fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_pc,
  input  logic            i_inc,
  output logic [PC_W-1:0] q_pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (i_load) begin
      pc_d = i_load_pc;
    end else if (i_inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign q_pc = pc_q;

endmodule

// File: rtl/prco_fetch.sv
// PRCO instruction fetch: one req/ack memory read per fetch, issued to the decoder as a q_ce pulse.
module prco_fetch
  import prco_fetch_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(PRCO_RESET_PC),
  parameter int              TIMEOUT_CYC = PRCO_FETCH_TIMEOUT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic            i_fetch,
  input  logic            i_pc_we,
  input  logic [PC_W-1:0] i_pc_d,
  output logic            q_mem_req,
  output logic [PC_W-1:0] q_mem_addr,
  input  logic            i_mem_ack,
  input  logic [15:0]     i_mem_data,
  output logic [15:0]     q_instr,
  output logic [PC_W-1:0] q_pc,
  output logic            q_ce,
  output logic            q_busy,
  output logic            q_fault
);

  localparam logic [TIMER_W-1:0] TIMEOUT_T  = TIMER_W'(TIMEOUT_CYC);
  localparam bit                 TIMEOUT_EN = (TIMEOUT_CYC != 0);

  fetch_state_e       state_q, state_d;
  logic               boot_q, boot_d;
  logic               flush_q, flush_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [15:0]        instr_q, instr_d;
  logic [PC_W-1:0]    opc_q, opc_d;
  logic               ce_q, ce_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;

  logic               pc_load, pc_inc;
  logic [PC_W-1:0]    pc;

  prco_fetch_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (pc_load),
    .i_load_pc (i_pc_d),
    .i_inc     (pc_inc),
    .q_pc      (pc)
  );

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    flush_d = flush_q;
    timer_d = timer_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    ce_d    = 1'b0;
    fault_d = fault_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pc_load = i_pc_we;
        if (i_en && (boot_q || i_fetch)) begin
          state_d = S_FETCH;
          boot_d  = 1'b0;
          req_d   = 1'b1;
          // A redirect in the launch cycle is already the address to fetch.
          addr_d  = i_pc_we ? i_pc_d : pc;
          timer_d = '0;
        end
      end
      S_FETCH: begin
        if (i_mem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          pc_load = i_pc_we;
          if (flush_q || i_pc_we) begin
            // Stale data from the pre-redirect address: drop it and refetch at the new PC.
            flush_d = 1'b0;
            boot_d  = 1'b1;
          end else begin
            instr_d = i_mem_data;
            opc_d   = pc;
            ce_d    = 1'b1;
            pc_inc  = 1'b1;
          end
        end else begin
          if (i_pc_we) begin
            pc_load = 1'b1;
            flush_d = 1'b1;
          end
          timer_d = timer_q + TIMER_W'(1);
          if (TIMEOUT_EN && (timer_d == TIMEOUT_T)) begin
            fault_d = 1'b1;
            req_d   = 1'b0;
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d == S_FETCH);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      boot_q  <= 1'b1;
      flush_q <= 1'b0;
      timer_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      opc_q   <= '0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      flush_q <= flush_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign q_mem_req  = req_q;
  assign q_mem_addr = addr_q;
  assign q_instr    = instr_q;
  assign q_pc       = opc_q;
  assign q_ce       = ce_q;
  assign q_busy     = busy_q;
  assign q_fault    = fault_q;

endmodule
